// File: rtl/multi_pwm_pkg.sv
// multi_pwm_pkg: shared constants and types for the multi-channel PWM block.
//   NCH_DEF, WIDTH_DEF, DEB_CYCLES_DEF : default parameter values
//   cnt_dir_e                          : counter direction, used only by the
//                                        centre-aligned build
//                                        (MULTI_PWM_CENTER_ALIGN_EN)
package multi_pwm_pkg;

  localparam int NCH_DEF        = 4;
  localparam int WIDTH_DEF      = 8;
  localparam int DEB_CYCLES_DEF = 512;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/multi_pwm_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, hold-time debouncer, single press pulse.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   btn_i   : raw asynchronous button, active-high
//   press_o : one-cycle pulse DEB_CYCLES cycles after the synchronized input
//             rises; any low cycle restarts the count; no repeat while held
module btn_debounce #(
  parameter int DEB_CYCLES = 512
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int            CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [1:0]    vld_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          press_q, press_d;

  // done_q comes out of reset set, so a button held through reset must be
  // seen low before it can fire again. vld_q masks the synchronizer's reset
  // value, which would otherwise look like a release.
  always_comb begin
    cnt_d   = cnt_q;
    done_d  = done_q;
    press_d = 1'b0;
    if (!sync2_q) begin
      cnt_d = CNT_LOAD;
      if (vld_q[1]) begin
        done_d = 1'b0;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (!done_q) begin
      press_d = 1'b1;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld_q   <= '0;
      cnt_q   <= CNT_LOAD;
      done_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/multi_pwm.sv
// multi_pwm: NCH PWM channels sharing one counter; three debounced buttons
// select a channel and nudge its duty. Edits go to a shadow duty that is
// copied to the active duty in the last cycle of each period.
//   clk, rst                 : clock, asynchronous active-high reset
//   btn_up, btn_dn, btn_sel  : raw buttons (increase, decrease, next channel)
//   pwm_out[NCH]             : registered PWM outputs
//   sel_ch                   : channel edited by the buttons
//   at_max, at_min           : active duty of sel_ch is MAX / 0
//   period_tick              : pulse in the last cycle of each PWM period
// Build option MULTI_PWM_CENTER_ALIGN_EN: centre-aligned counter
// (0..MAX then MAX-1..1, period 2*MAX); default is edge-aligned (0..MAX-1).
//
// Counter direction (centre-aligned build only)
//   state | meaning
//   UP    | counting 0 -> MAX
//   DOWN  | counting MAX-1 -> 1, then back to UP at 0
module multi_pwm
  import multi_pwm_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DUTY_INIT  = (2 ** WIDTH - 1) / 2,
  localparam int SELW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_up,
  input  logic            btn_dn,
  input  logic            btn_sel,
  output logic [NCH-1:0]  pwm_out,
  output logic [SELW-1:0] sel_ch,
  output logic            at_max,
  output logic            at_min,
  output logic            period_tick
);

  localparam logic [WIDTH-1:0] MAX      = '1;
  localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(DUTY_INIT);
  localparam logic [SELW-1:0]  SEL_LAST = SELW'(NCH - 1);

  logic up_p, dn_p, sel_p;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk_i(clk), .rst_i(rst), .btn_i(btn_up), .press_o(up_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk_i(clk), .rst_i(rst), .btn_i(btn_dn), .press_o(dn_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .clk_i(clk), .rst_i(rst), .btn_i(btn_sel), .press_o(sel_p)
  );

  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] shadow_q [NCH];
  logic [WIDTH-1:0] shadow_d [NCH];
  logic [WIDTH-1:0] active_q [NCH];
  logic [WIDTH-1:0] active_d [NCH];
  logic [SELW-1:0]  sel_q, sel_d;
  logic [NCH-1:0]   pwm_q, pwm_d;

`ifdef MULTI_PWM_CENTER_ALIGN_EN
  cnt_dir_e dir_q, dir_d;

  always_comb begin
    dir_d   = dir_q;
    count_d = count_q;
    unique case (dir_q)
      UP: begin
        if (count_q == MAX) begin
          dir_d   = DOWN;
          count_d = count_q - 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DOWN: begin
        if (count_q <= WIDTH'(1)) begin
          dir_d   = UP;
          count_d = '0;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    endcase
    // Registered from next-state so the tick lines up with count==1 falling.
    tick_d = (dir_d == DOWN) && (count_d == WIDTH'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir_q <= UP;
    else     dir_q <= dir_d;
  end
`else
  always_comb begin
    count_d = (count_q == MAX - 1'b1) ? '0 : count_q + 1'b1;
    tick_d  = (count_d == MAX - 1'b1);
  end
`endif

  // Up and down together cancel; a sel pulse in the same cycle still edits
  // the old channel because the duty update indexes sel_q.
  always_comb begin
    sel_d    = sel_q;
    shadow_d = shadow_q;
    active_d = active_q;
    if (up_p && !dn_p && (shadow_q[sel_q] != MAX)) begin
      shadow_d[sel_q] = shadow_q[sel_q] + 1'b1;
    end else if (dn_p && !up_p && (shadow_q[sel_q] != '0)) begin
      shadow_d[sel_q] = shadow_q[sel_q] - 1'b1;
    end
    if (sel_p) begin
      sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
    end
    if (tick_q) begin
      active_d = shadow_q;
    end
    for (int i = 0; i < NCH; i++) begin
      pwm_d[i] = (count_q < active_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      tick_q   <= 1'b0;
      sel_q    <= '0;
      shadow_q <= '{default: DUTY_RST};
      active_q <= '{default: DUTY_RST};
      pwm_q    <= '0;
    end else begin
      count_q  <= count_d;
      tick_q   <= tick_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign sel_ch      = sel_q;
  assign period_tick = tick_q;
  assign at_max      = (active_q[sel_q] == MAX);
  assign at_min      = (active_q[sel_q] == '0);

endmodule

// File: tb/tb_multi_pwm.sv
module tb_multi_pwm;

  localparam int NCH   = 4;
  localparam int WIDTH = 4;
  localparam int DEB   = 8;
  localparam int DINIT = 7;
  localparam int MAXV  = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_dn, btn_sel;
  logic [3:0] pwm_out;
  logic [1:0] sel_ch;
  logic       at_max, at_min, period_tick;

  multi_pwm #(
    .NCH(NCH), .WIDTH(WIDTH), .DEB_CYCLES(DEB), .DUTY_INIT(DINIT)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .btn_sel(btn_sel),
    .pwm_out(pwm_out), .sel_ch(sel_ch), .at_max(at_max), .at_min(at_min),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: the period position is simply the number of clock
  // edges since reset modulo MAX; a press is a run of exactly DEB
  // consecutive high synchronized samples.
  int       m_age;
  int       m_sh  [NCH];
  int       m_act [NCH];
  int       m_sel;
  bit [3:0] m_pwm;
  bit       m_s1 [3];
  bit       m_s2 [3];
  bit       m_pulse [3];
  bit       m_lock [3];
  int       m_run [3];
  int       hi_cnt [NCH];

  function automatic void model_reset();
    m_age = 0;
    m_sel = 0;
    m_pwm = '0;
    for (int i = 0; i < NCH; i++) begin
      m_sh[i]  = DINIT;
      m_act[i] = DINIT;
    end
    for (int j = 0; j < 3; j++) begin
      m_s1[j] = 0; m_s2[j] = 0; m_pulse[j] = 0; m_lock[j] = 1; m_run[j] = 0;
    end
  endfunction

  // b = {sel, dn, up}; all updates use the values of the cycle just ended.
  function automatic void model_edge(input bit [2:0] b);
    for (int i = 0; i < NCH; i++) m_pwm[i] = ((m_age % MAXV) < m_act[i]);
    if ((m_age % MAXV) == MAXV - 1) m_act = m_sh;
    if (m_pulse[0] && !m_pulse[1]) begin
      if (m_sh[m_sel] < MAXV) m_sh[m_sel] = m_sh[m_sel] + 1;
    end else if (m_pulse[1] && !m_pulse[0]) begin
      if (m_sh[m_sel] > 0) m_sh[m_sel] = m_sh[m_sel] - 1;
    end
    if (m_pulse[2]) m_sel = (m_sel + 1) % NCH;
    for (int j = 0; j < 3; j++) begin
      m_pulse[j] = m_s2[j] && (m_run[j] + 1 == DEB) && !m_lock[j];
      m_run[j]   = m_s2[j] ? m_run[j] + 1 : 0;
      if (!m_s2[j] && m_age >= 2) m_lock[j] = 0;
      m_s2[j] = m_s1[j];
      m_s1[j] = b[j];
    end
    m_age++;
  endfunction

  task automatic check_all();
    check_val("pwm_out", int'(pwm_out), int'(m_pwm));
    check_val("period_tick", int'(period_tick), int'((m_age % MAXV) == MAXV - 1));
    check_val("sel_ch", int'(sel_ch), m_sel);
    check_val("at_max", int'(at_max), int'(m_act[m_sel] == MAXV));
    check_val("at_min", int'(at_min), int'(m_act[m_sel] == 0));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge({btn_sel, btn_dn, btn_up});
      #1;
      check_all();
    end
  endtask

  task automatic measure();
    for (int i = 0; i < NCH; i++) hi_cnt[i] = 0;
    repeat (MAXV) begin
      step(1);
      for (int i = 0; i < NCH; i++) hi_cnt[i] += int'(pwm_out[i]);
    end
  endtask

  // which: 0 up, 1 dn, 2 sel
  task automatic press(input int which, input int hold);
    if (which == 0) btn_up = 1'b1;
    else if (which == 1) btn_dn = 1'b1;
    else btn_sel = 1'b1;
    step(hold);
    btn_up = 1'b0; btn_dn = 1'b0; btn_sel = 1'b0;
    step(4);
  endtask

  int t_first, t_second, hold;

  initial begin
    rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0; btn_sel = 1'b0;
    model_reset();
    #1;
    check_val("rst_pwm", int'(pwm_out), 0);
    check_val("rst_tick", int'(period_tick), 0);
    step(3);
    rst = 1'b0;

    // Reset release: duty 7/15, tick every 15 cycles, channel 0 selected
    t_first = -1; t_second = -1;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (period_tick) begin
        if (t_first < 0) t_first = c;
        else if (t_second < 0) t_second = c;
      end
    end
    check_val("tick_spacing", t_second - t_first, MAXV);
    check_val("sel_after_reset", int'(sel_ch), 0);
    measure();
    check_val("init_duty_ch0", hi_cnt[0], 7);
    check_val("init_duty_ch3", hi_cnt[3], 7);

    // Long hold gives a single increment on channel 0 only
    btn_up = 1'b1; step(20); btn_up = 1'b0; step(40);
    measure();
    check_val("hold_up_ch0", hi_cnt[0], 8);
    check_val("hold_up_ch1", hi_cnt[1], 7);

    // Bounced down button never reaches the hold time
    btn_dn = 1'b1; step(5); btn_dn = 1'b0; step(1); btn_dn = 1'b1; step(5);
    btn_dn = 1'b0; step(40);
    measure();
    check_val("bounce_ch0", hi_cnt[0], 8);

    // Saturate at MAX, then one more press
    for (int k = 0; k < 8; k++) press(0, 12);
    step(40);
    check_val("sat_at_max", int'(at_max), 1);
    press(0, 12);
    step(40);
    measure();
    check_val("sat_pwm_high", hi_cnt[0], MAXV);
    check_val("sat_still_max", int'(at_max), 1);

    // Back down to 12, then up and sel land together
    for (int k = 0; k < 3; k++) press(1, 12);
    step(40);
    btn_up = 1'b1; btn_sel = 1'b1; step(14);
    btn_up = 1'b0; btn_sel = 1'b0; step(40);
    check_val("same_cycle_sel", int'(sel_ch), 1);
    measure();
    check_val("same_cycle_ch0", hi_cnt[0], 13);
    check_val("same_cycle_ch1", hi_cnt[1], 7);

    // Reset mid-press with the button still held
    btn_up = 1'b1; step(6);
    rst = 1'b1; #1;
    model_reset();
    check_val("midrst_pwm", int'(pwm_out), 0);
    check_val("midrst_sel", int'(sel_ch), 0);
    step(2);
    rst = 1'b0;
    step(30);
    measure();
    check_val("held_thru_rst_ch0", hi_cnt[0], 7);
    btn_up = 1'b0; step(4);
    press(0, 12);
    step(40);
    measure();
    check_val("repress_ch0", hi_cnt[0], 8);

    // Random button traffic with occasional resets
    for (int k = 0; k < 60; k++) begin
      btn_up  = 1'($urandom_range(0, 1));
      btn_dn  = 1'($urandom_range(0, 1));
      btn_sel = 1'($urandom_range(0, 1));
      hold    = int'($urandom_range(1, 14));
      step(hold);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1; #1;
        model_reset();
        check_all();
        step(1);
        rst = 1'b0;
      end
    end
    btn_up = 1'b0; btn_dn = 1'b0; btn_sel = 1'b0;
    step(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_pwm.md
MULTI_PWM -- requirements
Module: multi_pwm

Interface
REQ-001 Parameter NCH, default 4, number of independent PWM channels (1..16).
REQ-002 Parameter WIDTH, default 8, bit width of the counter and duty values; MAX = 2^WIDTH-1.
REQ-003 Parameter DEB_CYCLES, default 512, consecutive high cycles needed to accept a button press (2..4095).
REQ-004 Parameter DUTY_INIT, default MAX/2 (integer division), reset duty for every channel.
REQ-005 Port clk  in  1  single system clock; all logic is on its rising edge.
REQ-006 Port rst  in  1  reset; asynchronous, active-high.
REQ-007 Port btn_up  in  1  raw, asynchronous "increase duty" button, active-high.
REQ-008 Port btn_dn  in  1  raw, asynchronous "decrease duty" button, active-high.
REQ-009 Port btn_sel  in  1  raw, asynchronous "next channel" button, active-high.
REQ-010 Port pwm_out  out  NCH  registered PWM outputs, one bit per channel.
REQ-011 Port sel_ch  out  max(1,clog2(NCH))  index of the channel the buttons edit.
REQ-012 Port at_max  out  1  selected channel's active duty equals MAX.
REQ-013 Port at_min  out  1  selected channel's active duty equals 0.
REQ-014 Port period_tick  out  1  one-cycle pulse in the last cycle of each PWM period.

Function
REQ-015 Each button passes through a 2-flop synchronizer before the debouncer.
REQ-016 The debouncer emits exactly one 1-cycle press pulse per press, DEB_CYCLES cycles after the synchronized input goes high; no repeat while held; any low cycle restarts the count.
REQ-017 Up pulse: the selected channel's shadow duty increments by 1 and saturates at MAX.
REQ-018 Down pulse: the selected channel's shadow duty decrements by 1 and saturates at 0.
REQ-019 Up and down pulses in the same cycle leave the shadow duty unchanged.
REQ-020 Sel pulse: sel_ch increments and wraps from NCH-1 to 0; an up/down pulse in the same cycle applies to the old channel.
REQ-021 A shared counter counts 0..MAX-1 and wraps, giving a period of MAX cycles; period_tick is high when count equals MAX-1.
REQ-022 Shadow duties are copied into the active duties on the cycle period_tick is high, so no period is glitched.
REQ-023 pwm_out[i] is registered as (count < active_duty[i]): 1-cycle latency; duty 0 gives constant low, duty MAX gives constant high.
REQ-024 at_max and at_min are combinational on the active duty of sel_ch.

Reset
REQ-025 While rst is high: count=0; sel_ch=0; all shadow and active duties=DUTY_INIT; pwm_out=0; period_tick=0; synchronizers, debounce counters and pulses cleared.
REQ-026 A press in progress when reset asserts is discarded; after reset deasserts, a still-held button must be released before it can register again.

Configuration
REQ-027 Macro MULTI_PWM_CENTER_ALIGN_EN.
- Defined: count goes up 0..MAX, then down MAX-1..1; period is 2*MAX cycles; period_tick fires when the count is 1 and falling; pwm_out[i] = (count < active_duty[i]).
- Undefined: edge-aligned behaviour per REQ-021.

Structure
REQ-028 Package multi_pwm_pkg holds the default parameter constants and the counter-direction enum (UP/DOWN), which is used only with MULTI_PWM_CENTER_ALIGN_EN.
REQ-029 Sub-module btn_debounce (synchronizer, DEB_CYCLES counter, single-pulse output) is instantiated three times.

Verification (NCH=4, WIDTH=4 so MAX=15, DEB_CYCLES=8, DUTY_INIT=7)
REQ-030 Reset release -> all pwm_out are high for 7 of every 15 cycles; period_tick has a 15-cycle spacing; sel_ch=0.
REQ-031 Hold btn_up for 20 cycles -> one pulse only; ch0 duty becomes 8 at the next period_tick; ch1..3 stay at 7.
REQ-032 Bounce btn_dn as 5 high, 1 low, 5 high cycles -> no pulse and no duty change.
REQ-033 Eight up presses on ch0 -> duty reaches 15 and at_max=1; a ninth press keeps it at 15 with pwm_out[0] constantly high.
REQ-034 Press btn_sel with btn_up held so both pulses land in the same cycle -> ch0 increments; sel_ch=1; ch1 unchanged.
REQ-035 Assert rst mid-period with btn_up held for 6 cycles -> outputs are reset, and no up pulse occurs until the button is released and pressed again.
